// File: rtl/simd_ins_sequencer_if.sv
// Bus bundle for simd_ins_sequencer: PS handshake, instruction BRAM, BRAM A/B/R and PE control.
// With SEQ_PERF_CNT_EN defined it also carries perf_cycles and perf_stalls.
interface simd_ins_sequencer_if #(
   parameter int ADDR_WIDTH     = 10,
   parameter int INS_ADDR_WIDTH = 11,
   parameter int INS_WIDTH      = 64
);
   logic                      start;
   logic                      stall;
   logic                      busy;
   logic                      done;
   logic                      err;
   logic                      ins_rd_en;
   logic [INS_ADDR_WIDTH-1:0] ins_rd_addr;
   logic [INS_WIDTH-1:0]      ins_rd_data;
   logic                      a_rd_en;
   logic [ADDR_WIDTH-1:0]     a_rd_addr;
   logic                      b_rd_en;
   logic [ADDR_WIDTH-1:0]     b_rd_addr;
   logic [3:0]                pe_op;
   logic                      pe_valid;
   logic                      r_wr_en;
   logic [ADDR_WIDTH-1:0]     r_wr_addr;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0]               perf_cycles;
   logic [31:0]               perf_stalls;

   modport master (
      input  start, stall, ins_rd_data,
      output busy, done, err, ins_rd_en, ins_rd_addr,
      output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
      output pe_op, pe_valid, r_wr_en, r_wr_addr,
      output perf_cycles, perf_stalls
   );

   modport slave (
      output start, stall, ins_rd_data,
      input  busy, done, err, ins_rd_en, ins_rd_addr,
      input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
      input  pe_op, pe_valid, r_wr_en, r_wr_addr,
      input  perf_cycles, perf_stalls
   );
`else
   modport master (
      input  start, stall, ins_rd_data,
      output busy, done, err, ins_rd_en, ins_rd_addr,
      output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
      output pe_op, pe_valid, r_wr_en, r_wr_addr
   );

   modport slave (
      output start, stall, ins_rd_data,
      input  busy, done, err, ins_rd_en, ins_rd_addr,
      input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
      input  pe_op, pe_valid, r_wr_en, r_wr_addr
   );
`endif
endinterface

// File: rtl/simd_ins_sequencer.sv
// Fetches/decodes 64-bit SIMD instructions, streams A/B row reads and delays R write-back by the PE latency.
// Optional SEQ_PERF_CNT_EN adds busy-cycle and stall-cycle counters.
module simd_ins_sequencer #(
   parameter int ADDR_WIDTH     = 10,
   parameter int INS_ADDR_WIDTH = 11,
   parameter int INS_WIDTH      = 64,
   parameter int LEN_WIDTH      = 12,
   parameter int PE_LATENCY     = 2
) (
   input logic                  clk,
   input logic                  rst,
   simd_ins_sequencer_if.master bus
);
   localparam int unsigned DEPTH   = PE_LATENCY + 1;
   localparam logic [3:0]  OP_NOP  = 4'h0;
   localparam logic [3:0]  OP_HALT = 4'hF;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic                  v;
      logic [3:0]            op;
      logic [ADDR_WIDTH-1:0] addr;
   } wb_t;

   state_t                    r_state;
   logic [INS_ADDR_WIDTH-1:0] r_pc;
   logic [LEN_WIDTH-1:0]      r_remain;
   logic [3:0]                r_op;
   logic [ADDR_WIDTH-1:0]     r_a_addr;
   logic [ADDR_WIDTH-1:0]     r_b_addr;
   logic [ADDR_WIDTH-1:0]     r_r_addr;
   logic                      r_err;
   wb_t                       r_pipe [DEPTH];

   logic [3:0]                w_op;
   logic [LEN_WIDTH-1:0]      w_len;
   logic [ADDR_WIDTH-1:0]     w_r_base;
   logic [ADDR_WIDTH-1:0]     w_a_base;
   logic [ADDR_WIDTH-1:0]     w_b_base;
   logic                      w_halt;
   logic                      w_nop;
   logic                      w_alu;
   logic                      w_pc_last;
   logic                      w_pipe_busy;

   assign w_op      = bus.ins_rd_data[INS_WIDTH-1 -: 4];
   assign w_len     = bus.ins_rd_data[INS_WIDTH-5 -: LEN_WIDTH];
   assign w_r_base  = bus.ins_rd_data[3*ADDR_WIDTH-1 : 2*ADDR_WIDTH];
   assign w_a_base  = bus.ins_rd_data[2*ADDR_WIDTH-1 : ADDR_WIDTH];
   assign w_b_base  = bus.ins_rd_data[ADDR_WIDTH-1 : 0];
   assign w_halt    = (w_op == OP_HALT);
   assign w_nop     = (w_op == OP_NOP);
   assign w_alu     = (w_op >= 4'h1) && (w_op <= 4'h5);
   assign w_pc_last = (r_pc == '1);

   always_comb begin
      w_pipe_busy = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) w_pipe_busy = w_pipe_busy | r_pipe[k].v;
   end

   // The last pc slot ends the program like a HALT instead of wrapping to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_pc     <= '0;
         r_remain <= '0;
         r_op     <= '0;
         r_a_addr <= '0;
         r_b_addr <= '0;
         r_r_addr <= '0;
         r_err    <= 1'b0;
      end else if (!bus.stall) begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_err   <= 1'b0;
                  r_pc    <= '0;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               if (w_halt) begin
                  r_state <= S_DRAIN;
               end else if (!w_nop && !w_alu) begin
                  r_err   <= 1'b1;
                  r_state <= S_DRAIN;
               end else if (w_nop || (w_len == '0)) begin
                  if (w_pc_last) r_state <= S_DRAIN;
                  else begin
                     r_pc    <= r_pc + INS_ADDR_WIDTH'(1);
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_op     <= w_op;
                  r_a_addr <= w_a_base;
                  r_b_addr <= w_b_base;
                  r_r_addr <= w_r_base;
                  r_remain <= w_len - LEN_WIDTH'(1);
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_remain == '0) begin
                  if (w_pc_last) r_state <= S_DRAIN;
                  else begin
                     r_pc    <= r_pc + INS_ADDR_WIDTH'(1);
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_remain <= r_remain - LEN_WIDTH'(1);
                  r_a_addr <= r_a_addr + ADDR_WIDTH'(1);
                  r_b_addr <= r_b_addr + ADDR_WIDTH'(1);
                  r_r_addr <= r_r_addr + ADDR_WIDTH'(1);
               end
            end
            S_DRAIN: if (!w_pipe_busy) r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stage 0 is the PE operand stage; the last stage is the R write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
      end else if (!bus.stall) begin
         r_pipe[0] <= '{v: (r_state == S_EXEC), op: r_op, addr: r_r_addr};
         for (int unsigned k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign bus.busy        = (r_state != S_IDLE) && (r_state != S_DONE);
   assign bus.done        = (r_state == S_DONE);
   assign bus.err         = r_err;
   assign bus.ins_rd_en   = (r_state == S_FETCH) && !bus.stall;
   assign bus.ins_rd_addr = r_pc;
   assign bus.a_rd_en     = (r_state == S_EXEC) && !bus.stall;
   assign bus.a_rd_addr   = r_a_addr;
   assign bus.b_rd_en     = (r_state == S_EXEC) && !bus.stall;
   assign bus.b_rd_addr   = r_b_addr;
   assign bus.pe_op       = r_pipe[0].op;
   assign bus.pe_valid    = r_pipe[0].v && !bus.stall;
   assign bus.r_wr_en     = r_pipe[DEPTH-1].v && !bus.stall;
   assign bus.r_wr_addr   = r_pipe[DEPTH-1].addr;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] r_perf_cycles;
   logic [31:0] r_perf_stalls;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_cycles <= '0;
         r_perf_stalls <= '0;
      end else if (!bus.stall && bus.start && !bus.busy) begin
         r_perf_cycles <= '0;
         r_perf_stalls <= '0;
      end else begin
         if (bus.busy && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + 32'd1;
         if (bus.busy && bus.stall && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 32'd1;
      end
   end

   assign bus.perf_cycles = r_perf_cycles;
   assign bus.perf_stalls = r_perf_stalls;
`endif
endmodule

// File: tb/tb_simd_ins_sequencer.sv
// Directed bench for simd_ins_sequencer: cycle numbers count from the edge that samples start (edge 0).
module tb_simd_ins_sequencer;
   localparam int AW  = 10;
   localparam int IAW = 11;
   localparam int IW  = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   simd_ins_sequencer_if #(.ADDR_WIDTH(AW), .INS_ADDR_WIDTH(IAW), .INS_WIDTH(IW)) bus ();

   simd_ins_sequencer #(
      .ADDR_WIDTH(AW), .INS_ADDR_WIDTH(IAW), .INS_WIDTH(IW), .LEN_WIDTH(12), .PE_LATENCY(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [IW-1:0] imem [0:(1<<IAW)-1];
   always @(posedge clk) if (bus.ins_rd_en) bus.ins_rd_data <= imem[bus.ins_rd_addr];

   int checks = 0;
   int errors = 0;

   int rd_cyc[$], rd_a[$], rd_b[$], pe_cyc[$], pe_op_q[$], wr_cyc[$], wr_a[$];
   int done_cyc, err_first, en_in_stall, ab_mismatch, n_fetch, n_fetch0, max_pc, first_fetch;
   logic err_last, err_at1;

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic logic [IW-1:0] mk(input int op, input int len, input int r, input int a, input int b);
      logic [IW-1:0] w;
      w = '0;
      w[63:60] = op[3:0];
      w[59:48] = len[11:0];
      w[29:20] = r[9:0];
      w[19:10] = a[9:0];
      w[9:0]   = b[9:0];
      return w;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < (1 << IAW); i++) imem[i] = '0;
   endtask

   // Pulses start so edge 0 samples it, then samples outputs at the negedge of cycles 1..ncyc.
   task automatic run_prog(input int ncyc, input int stall_lo, input int stall_hi, input int start_at);
      rd_cyc.delete(); rd_a.delete(); rd_b.delete(); pe_cyc.delete(); pe_op_q.delete();
      wr_cyc.delete(); wr_a.delete();
      done_cyc = -1; err_first = -1; en_in_stall = 0; ab_mismatch = 0;
      n_fetch = 0; n_fetch0 = 0; max_pc = -1; first_fetch = -1; err_last = 1'bx; err_at1 = 1'bx;
      @(negedge clk); bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      for (int cyc = 1; cyc <= ncyc; cyc++) begin
         if (cyc > 1) begin @(posedge clk); #1; end
         bus.stall = (cyc >= stall_lo) && (cyc <= stall_hi);
         bus.start = (cyc == start_at);
         @(negedge clk);
         if (bus.a_rd_en) begin rd_cyc.push_back(cyc); rd_a.push_back(int'(bus.a_rd_addr)); rd_b.push_back(int'(bus.b_rd_addr)); end
         if (bus.a_rd_en !== bus.b_rd_en) ab_mismatch++;
         if (bus.pe_valid) begin pe_cyc.push_back(cyc); pe_op_q.push_back(int'(bus.pe_op)); end
         if (bus.r_wr_en) begin wr_cyc.push_back(cyc); wr_a.push_back(int'(bus.r_wr_addr)); end
         if (bus.stall && (bus.ins_rd_en || bus.a_rd_en || bus.b_rd_en || bus.pe_valid || bus.r_wr_en)) en_in_stall++;
         if (bus.ins_rd_en) begin
            n_fetch++;
            if (first_fetch < 0) first_fetch = int'(bus.ins_rd_addr);
            if (bus.ins_rd_addr == '0) n_fetch0++;
            if (int'(bus.ins_rd_addr) > max_pc) max_pc = int'(bus.ins_rd_addr);
         end
         if (bus.done && done_cyc < 0) done_cyc = cyc;
         if (bus.err && err_first < 0) err_first = cyc;
         if (cyc == 1) err_at1 = bus.err;
         err_last = bus.err;
      end
      bus.stall = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({bus.busy, bus.done, bus.err, bus.ins_rd_en, bus.ins_rd_addr, bus.a_rd_en, bus.a_rd_addr, bus.b_rd_en,
           bus.b_rd_addr, bus.pe_op, bus.pe_valid, bus.r_wr_en, bus.r_wr_addr} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy %b done %b err %b ins_en %b a_en %b pe_v %b wr_en %b required all 0",
                  bus.busy, bus.done, bus.err, bus.ins_rd_en, bus.a_rd_en, bus.pe_valid, bus.r_wr_en);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      int exp_rd[4] = '{3, 4, 5, 6};
      int exp_pe[4] = '{4, 5, 6, 7};
      int exp_wr[4] = '{6, 7, 8, 9};
      clear_mem();
      imem[0] = mk(1, 4, 0, 0, 0);
      imem[1] = mk(15, 0, 0, 0, 0);
      run_prog(14, 0, 0, 0);
      checks++;
      if (rd_cyc.size() != 4 || pe_cyc.size() != 4 || wr_cyc.size() != 4) begin
         errors++;
         $display("FAIL basic_counts: rd %0d pe %0d wr %0d required 4 4 4", rd_cyc.size(), pe_cyc.size(), wr_cyc.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (qget(rd_cyc, i) !== exp_rd[i] || qget(rd_a, i) !== i || qget(rd_b, i) !== i) begin
            errors++;
            $display("FAIL basic_rd%0d: cyc %0d a %0d b %0d required cyc %0d a %0d b %0d",
                     i, qget(rd_cyc, i), qget(rd_a, i), qget(rd_b, i), exp_rd[i], i, i);
         end
         checks++;
         if (qget(pe_cyc, i) !== exp_pe[i] || qget(pe_op_q, i) !== 1) begin
            errors++;
            $display("FAIL basic_pe%0d: cyc %0d op %0d required cyc %0d op 1", i, qget(pe_cyc, i), qget(pe_op_q, i), exp_pe[i]);
         end
         checks++;
         if (qget(wr_cyc, i) !== exp_wr[i] || qget(wr_a, i) !== i) begin
            errors++;
            $display("FAIL basic_wr%0d: cyc %0d addr %0d required cyc %0d addr %0d", i, qget(wr_cyc, i), qget(wr_a, i), exp_wr[i], i);
         end
      end
      checks++;
      if (done_cyc !== 11 || err_last !== 1'b0 || ab_mismatch !== 0) begin
         errors++;
         $display("FAIL basic_done: done_cyc %0d err %b ab_mismatch %0d required 11 0 0", done_cyc, err_last, ab_mismatch);
      end
   endtask

   task automatic test_stall();
      int exp_rd[4] = '{3, 4, 9, 10};
      int exp_pe[4] = '{4, 9, 10, 11};
      int exp_wr[4] = '{10, 11, 12, 13};
      clear_mem();
      imem[0] = mk(1, 4, 0, 0, 0);
      imem[1] = mk(15, 0, 0, 0, 0);
      run_prog(18, 5, 8, 0);
      checks++;
      if (rd_cyc.size() != 4 || pe_cyc.size() != 4 || wr_cyc.size() != 4 || en_in_stall != 0) begin
         errors++;
         $display("FAIL stall_counts: rd %0d pe %0d wr %0d en_in_stall %0d required 4 4 4 0",
                  rd_cyc.size(), pe_cyc.size(), wr_cyc.size(), en_in_stall);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (qget(rd_cyc, i) !== exp_rd[i] || qget(rd_a, i) !== i || qget(pe_cyc, i) !== exp_pe[i] ||
             qget(wr_cyc, i) !== exp_wr[i] || qget(wr_a, i) !== i) begin
            errors++;
            $display("FAIL stall_row%0d: rd %0d@%0d pe @%0d wr %0d@%0d required rd %0d@%0d pe @%0d wr %0d@%0d",
                     i, qget(rd_a, i), qget(rd_cyc, i), qget(pe_cyc, i), qget(wr_a, i), qget(wr_cyc, i),
                     i, exp_rd[i], exp_pe[i], i, exp_wr[i]);
         end
      end
      checks++;
      if (done_cyc !== 15) begin
         errors++;
         $display("FAIL stall_done: done_cyc %0d required 15", done_cyc);
      end
   endtask

   task automatic test_wrap_addr();
      clear_mem();
      imem[0] = mk(0, 0, 0, 0, 0);
      imem[1] = mk(2, 0, 7, 7, 7);
      imem[2] = mk(3, 2, 1023, 1022, 5);
      imem[3] = mk(15, 0, 0, 0, 0);
      run_prog(16, 0, 0, 0);
      checks++;
      if (rd_cyc.size() != 2 || qget(rd_cyc, 0) !== 7 || qget(rd_a, 0) !== 1022 || qget(rd_a, 1) !== 1023 ||
          qget(rd_b, 0) !== 5 || qget(rd_b, 1) !== 6) begin
         errors++;
         $display("FAIL wrap_rd: n %0d cyc0 %0d a %0d,%0d b %0d,%0d required 2 7 1022,1023 5,6",
                  rd_cyc.size(), qget(rd_cyc, 0), qget(rd_a, 0), qget(rd_a, 1), qget(rd_b, 0), qget(rd_b, 1));
      end
      checks++;
      if (pe_cyc.size() != 2 || qget(pe_op_q, 0) !== 3 || qget(pe_op_q, 1) !== 3) begin
         errors++;
         $display("FAIL wrap_pe: n %0d op %0d,%0d required 2 3,3", pe_cyc.size(), qget(pe_op_q, 0), qget(pe_op_q, 1));
      end
      checks++;
      if (wr_cyc.size() != 2 || qget(wr_cyc, 0) !== 10 || qget(wr_a, 0) !== 1023 || qget(wr_a, 1) !== 0) begin
         errors++;
         $display("FAIL wrap_wr: n %0d cyc0 %0d addr %0d,%0d required 2 10 1023,0",
                  wr_cyc.size(), qget(wr_cyc, 0), qget(wr_a, 0), qget(wr_a, 1));
      end
      checks++;
      if (done_cyc !== 13 || err_last !== 1'b0) begin
         errors++;
         $display("FAIL wrap_done: done_cyc %0d err %b required 13 0", done_cyc, err_last);
      end
   endtask

   task automatic test_illegal();
      clear_mem();
      imem[0] = mk(9, 3, 1, 1, 1);
      imem[1] = mk(1, 2, 0, 0, 0);
      run_prog(8, 0, 0, 0);
      checks++;
      if (rd_cyc.size() != 0 || pe_cyc.size() != 0 || wr_cyc.size() != 0) begin
         errors++;
         $display("FAIL illegal_enables: rd %0d pe %0d wr %0d required 0 0 0", rd_cyc.size(), pe_cyc.size(), wr_cyc.size());
      end
      checks++;
      if (err_first !== 3 || err_last !== 1'b1 || done_cyc !== 4) begin
         errors++;
         $display("FAIL illegal_err: err_first %0d err %b done_cyc %0d required 3 1 4", err_first, err_last, done_cyc);
      end
      imem[0] = mk(15, 0, 0, 0, 0);
      run_prog(6, 0, 0, 0);
      checks++;
      if (err_at1 !== 1'b0 || err_last !== 1'b0 || done_cyc !== 4) begin
         errors++;
         $display("FAIL illegal_clear: err@1 %b err %b done_cyc %0d required 0 0 4", err_at1, err_last, done_cyc);
      end
   endtask

   task automatic test_reset_mid();
      int late_wr = 0;
      int late_busy = 0;
      clear_mem();
      imem[0] = mk(1, 8, 16, 0, 0);
      imem[1] = mk(15, 0, 0, 0, 0);
      run_prog(5, 0, 0, 0);
      checks++;
      if (rd_cyc.size() != 3) begin
         errors++;
         $display("FAIL rstmid_pre: reads %0d required 3", rd_cyc.size());
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.err, bus.ins_rd_en, bus.a_rd_en, bus.a_rd_addr, bus.b_rd_en, bus.pe_op,
           bus.pe_valid, bus.r_wr_en, bus.r_wr_addr} !== '0) begin
         errors++;
         $display("FAIL rstmid_async: busy %b a_en %b a %0d pe_v %b wr_en %b required all 0",
                  bus.busy, bus.a_rd_en, bus.a_rd_addr, bus.pe_valid, bus.r_wr_en);
      end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.r_wr_en) late_wr++;
         if (bus.busy) late_busy++;
      end
      checks++;
      if (late_wr != 0 || late_busy != 0) begin
         errors++;
         $display("FAIL rstmid_quiet: writes %0d busy cycles %0d required 0 0", late_wr, late_busy);
      end
      run_prog(17, 0, 0, 0);
      checks++;
      if (first_fetch !== 0 || rd_cyc.size() != 8 || qget(rd_cyc, 0) !== 3 || qget(rd_a, 7) !== 7 || qget(rd_cyc, 7) !== 10) begin
         errors++;
         $display("FAIL rstmid_rerun_rd: pc0 %0d n %0d first@%0d last %0d@%0d required 0 8 3 7@10",
                  first_fetch, rd_cyc.size(), qget(rd_cyc, 0), qget(rd_a, 7), qget(rd_cyc, 7));
      end
      checks++;
      if (wr_cyc.size() != 8 || qget(wr_a, 0) !== 16 || qget(wr_cyc, 0) !== 6 || qget(wr_a, 7) !== 23 ||
          qget(wr_cyc, 7) !== 13 || done_cyc !== 15) begin
         errors++;
         $display("FAIL rstmid_rerun_wr: n %0d %0d@%0d .. %0d@%0d done %0d required 8 16@6 .. 23@13 15",
                  wr_cyc.size(), qget(wr_a, 0), qget(wr_cyc, 0), qget(wr_a, 7), qget(wr_cyc, 7), done_cyc);
      end
   endtask

   task automatic test_start_busy();
      int pulses[4] = '{2, 4, 8, 10};
      clear_mem();
      imem[0] = mk(1, 4, 0, 0, 0);
      imem[1] = mk(15, 0, 0, 0, 0);
      for (int p = 0; p < 4; p++) begin
         run_prog(14, 0, 0, pulses[p]);
         checks++;
         if (n_fetch != 2 || n_fetch0 != 1 || rd_cyc.size() != 4 || qget(rd_cyc, 3) !== 6 || qget(rd_a, 3) !== 3 ||
             wr_cyc.size() != 4 || qget(wr_cyc, 3) !== 9 || done_cyc !== 11) begin
            errors++;
            $display("FAIL start_busy@%0d: fetch %0d pc0 %0d rd %0d last %0d@%0d wr %0d last@%0d done %0d required 2 1 4 3@6 4 9 11",
                     pulses[p], n_fetch, n_fetch0, rd_cyc.size(), qget(rd_a, 3), qget(rd_cyc, 3),
                     wr_cyc.size(), qget(wr_cyc, 3), done_cyc);
         end
      end
   endtask

   task automatic test_pc_wrap();
      clear_mem();
      run_prog(4102, 0, 0, 0);
      checks++;
      if (n_fetch != 2048 || n_fetch0 != 1 || max_pc != 2047 || done_cyc !== 4098 || err_last !== 1'b0) begin
         errors++;
         $display("FAIL pc_wrap: fetches %0d pc0 %0d max_pc %0d done %0d err %b required 2048 1 2047 4098 0",
                  n_fetch, n_fetch0, max_pc, done_cyc, err_last);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.stall = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_wrap_addr();
      test_illegal();
      test_reset_mid();
      test_start_busy();
      test_pc_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
